bp_resolve: RTL and testbench

//  Carries each fetched instruction's prediction (predicted next PC, PHT index) through IF/ID and ID/EX.

---
 rtl/bp_pkg.sv | 28 ++
 rtl/bp_resolve_if.sv | 43 ++++
 rtl/bp_stage_reg.sv | 23 ++
 rtl/bp_resolve.sv | 99 +++++++++
 tb/tb_bp_resolve.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared constants and types for the branch-resolution slice.
// Optional perf counters are enabled with BP_PERF_CNT_EN.
package bp_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned PHT_IDX_W = 5;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      pred_npc;
        logic [PHT_IDX_W-1:0] pht_idx;
    } pred_info_t;

    typedef struct packed {
        pred_info_t info;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
    } id_ex_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/bp_resolve_if.sv
// Fetch/decode/execute inputs and resolution outputs of bp_resolve.
interface bp_resolve_if;
    import bp_pkg::*;

    logic [XLEN-1:0]      if_pc;
    logic [XLEN-1:0]      if_pred_npc;
    logic [PHT_IDX_W-1:0] if_pht_index;
    logic                 stall;
    logic                 id_is_branch;
    logic                 id_is_jal;
    logic                 id_is_jalr;
    logic                 ex_cond_true;
    logic [XLEN-1:0]      ex_br_target;
    logic [XLEN-1:0]      ex_jalr_target;

    logic                 is_branch;
    logic                 is_jal;
    logic                 is_jalr;
    logic                 actual_taken;
    logic [XLEN-1:0]      actual_branch_target;
    logic                 prediction_correct;
    logic [PHT_IDX_W-1:0] pht_update_index;
    logic [XLEN-1:0]      ID_EX_pc;
    logic                 redirect;
    logic [XLEN-1:0]      redirect_pc;

    modport master (
        output if_pc, if_pred_npc, if_pht_index, stall,
               id_is_branch, id_is_jal, id_is_jalr,
               ex_cond_true, ex_br_target, ex_jalr_target,
        input  is_branch, is_jal, is_jalr, actual_taken, actual_branch_target,
               prediction_correct, pht_update_index, ID_EX_pc, redirect, redirect_pc
    );

    modport slave (
        input  if_pc, if_pred_npc, if_pht_index, stall,
               id_is_branch, id_is_jal, id_is_jalr,
               ex_cond_true, ex_br_target, ex_jalr_target,
        output is_branch, is_jal, is_jalr, actual_taken, actual_branch_target,
               prediction_correct, pht_update_index, ID_EX_pc, redirect, redirect_pc
    );

endinterface

// File: rtl/bp_stage_reg.sv
// Prediction-info pipeline register; clear beats hold beats load.
module bp_stage_reg
    import bp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       hold,
    input  pred_info_t d,
    output pred_info_t q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clear) begin
            q.valid <= 1'b0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/bp_resolve.sv
// Carries fetch-time predictions to EX, resolves them, and drives predictor
// update plus pipeline redirect. BP_PERF_CNT_EN adds control/mispredict counters.
module bp_resolve
    import bp_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    bp_resolve_if.slave  bus
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0]  perf_ctrl_cnt,
    output logic [31:0]  perf_mispred_cnt
`endif
);

    pred_info_t      if_id_d;
    pred_info_t      if_id_q;
    id_ex_t          id_ex_q;

    logic            ex_valid;
    logic            ex_is_ctrl;
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] actual_npc;
    logic            correct;
    logic            redirect_int;

    assign if_id_d = '{valid:    1'b1,
                       pc:       bus.if_pc,
                       pred_npc: bus.if_pred_npc,
                       pht_idx:  bus.if_pht_index};

    bp_stage_reg u_if_id (
        .clk   (clk),
        .reset (reset),
        .clear (redirect_int),
        .hold  (bus.stall),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    // Only valid is dropped on squash/bubble; payload is masked at the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_ex_q <= '0;
        end else if (redirect_int || bus.stall) begin
            id_ex_q.info.valid <= 1'b0;
        end else begin
            id_ex_q.info      <= if_id_q;
            id_ex_q.is_branch <= bus.id_is_branch & if_id_q.valid;
            id_ex_q.is_jal    <= bus.id_is_jal    & if_id_q.valid;
            id_ex_q.is_jalr   <= bus.id_is_jalr   & if_id_q.valid;
        end
    end

    always_comb begin
        ex_valid     = id_ex_q.info.valid;
        ex_is_ctrl   = id_ex_q.is_branch | id_ex_q.is_jal | id_ex_q.is_jalr;
        taken        = id_ex_q.is_jal | id_ex_q.is_jalr |
                       (id_ex_q.is_branch & bus.ex_cond_true);
        target       = id_ex_q.is_jalr ? bus.ex_jalr_target : bus.ex_br_target;
        actual_npc   = taken ? target : (id_ex_q.info.pc + PC_STEP);
        correct      = (id_ex_q.info.pred_npc == actual_npc);
        redirect_int = ex_valid & ~correct;
    end

    always_comb begin
        bus.is_branch            = ex_valid & id_ex_q.is_branch;
        bus.is_jal               = ex_valid & id_ex_q.is_jal;
        bus.is_jalr              = ex_valid & id_ex_q.is_jalr;
        bus.actual_taken         = ex_valid & taken;
        bus.actual_branch_target = ex_valid ? target : '0;
        bus.prediction_correct   = ex_valid & correct;
        bus.pht_update_index     = ex_valid ? id_ex_q.info.pht_idx : '0;
        bus.ID_EX_pc             = ex_valid ? id_ex_q.info.pc : '0;
        bus.redirect             = redirect_int;
        bus.redirect_pc          = ex_valid ? actual_npc : '0;
    end

`ifdef BP_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_ctrl_cnt    <= '0;
            perf_mispred_cnt <= '0;
        end else begin
            if (ex_valid && ex_is_ctrl) begin
                perf_ctrl_cnt <= sat_inc32(perf_ctrl_cnt);
            end
            if (redirect_int) begin
                perf_mispred_cnt <= sat_inc32(perf_mispred_cnt);
            end
        end
    end
`else
    logic unused_ctrl;
    assign unused_ctrl = ex_is_ctrl;
`endif

endmodule

// File: tb/tb_bp_resolve.sv
// Self-checking bench for bp_resolve: directed cases then randomized traffic
// against an instruction-level reference model.
module tb_bp_resolve;
    import bp_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bp_resolve_if bus();

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_ctrl_cnt;
    logic [31:0] perf_mispred_cnt;
`endif

    bp_resolve dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef BP_PERF_CNT_EN
        ,
        .perf_ctrl_cnt    (perf_ctrl_cnt),
        .perf_mispred_cnt (perf_mispred_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // One in-flight instruction as the model sees it.
    typedef struct {
        bit          v;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [4:0]  idx;
        bit          b, j, jr;
    } slot_t;

    typedef struct packed {
        logic        isb, isj, isjr, taken, correct, redirect;
        logic [31:0] target, rpc, pc;
        logic [4:0]  idx;
    } exp_t;

    slot_t           m_f, m_e;
    longint unsigned m_ctrl, m_misp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Where execution really goes next, decided by instruction kind.
    function automatic exp_t expect_now(input slot_t e, input bit cond,
                                        input logic [31:0] bt, input logic [31:0] jt);
        exp_t x = '0;
        if (!e.v) return x;
        x.isb = e.b; x.isj = e.j; x.isjr = e.jr;
        x.pc  = e.pc; x.idx = e.idx;
        x.target = e.jr ? jt : bt;
        if (e.j)                 begin x.taken = 1; x.rpc = bt; end
        else if (e.jr)           begin x.taken = 1; x.rpc = jt; end
        else if (e.b && cond)    begin x.taken = 1; x.rpc = bt; end
        else                     begin x.taken = 0; x.rpc = e.pc + 32'd4; end
        x.correct  = (e.npc == x.rpc);
        x.redirect = !x.correct;
        return x;
    endfunction

    function automatic exp_t cur_exp();
        return expect_now(m_e, bus.ex_cond_true, bus.ex_br_target, bus.ex_jalr_target);
    endfunction

    task automatic check_all(input string tag);
        exp_t x = cur_exp();
        chk({tag, ".is_branch"}, 32'(bus.is_branch),          32'(x.isb));
        chk({tag, ".is_jal"},    32'(bus.is_jal),             32'(x.isj));
        chk({tag, ".is_jalr"},   32'(bus.is_jalr),            32'(x.isjr));
        chk({tag, ".taken"},     32'(bus.actual_taken),       32'(x.taken));
        chk({tag, ".target"},    bus.actual_branch_target,    x.target);
        chk({tag, ".correct"},   32'(bus.prediction_correct), 32'(x.correct));
        chk({tag, ".pht_idx"},   32'(bus.pht_update_index),   32'(x.idx));
        chk({tag, ".ex_pc"},     bus.ID_EX_pc,                x.pc);
        chk({tag, ".redirect"},  32'(bus.redirect),           32'(x.redirect));
        chk({tag, ".redir_pc"},  bus.redirect_pc,             x.rpc);
`ifdef BP_PERF_CNT_EN
        chk({tag, ".perf_ctrl"}, perf_ctrl_cnt,
            (m_ctrl > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_ctrl[31:0]);
        chk({tag, ".perf_misp"}, perf_mispred_cnt,
            (m_misp > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_misp[31:0]);
`endif
    endtask

    task automatic model_reset();
        m_f = '{default: 0};
        m_e = '{default: 0};
        m_ctrl = 0;
        m_misp = 0;
    endtask

    task automatic set_in(input logic [31:0] pc, input logic [31:0] npc, input logic [4:0] idx,
                          input bit st, input bit b, input bit j, input bit jr, input bit c,
                          input logic [31:0] bt, input logic [31:0] jt, input string tag);
        bus.if_pc = pc; bus.if_pred_npc = npc; bus.if_pht_index = idx;
        bus.stall = st;
        bus.id_is_branch = b; bus.id_is_jal = j; bus.id_is_jalr = jr;
        bus.ex_cond_true = c; bus.ex_br_target = bt; bus.ex_jalr_target = jt;
        #1;
        check_all(tag);
    endtask

    task automatic tick();
        exp_t  x = cur_exp();
        slot_t nf;
        nf = '{v: 1, pc: bus.if_pc, npc: bus.if_pred_npc, idx: bus.if_pht_index,
               b: 0, j: 0, jr: 0};
        @(posedge clk);
        if (!reset) begin
            if (m_e.v && (m_e.b || m_e.j || m_e.jr)) m_ctrl++;
            if (x.redirect) m_misp++;
            if (x.redirect) begin
                m_f.v = 0;
                m_e.v = 0;
            end else if (bus.stall) begin
                m_e.v = 0;
            end else begin
                m_e    = m_f;
                m_e.b  = bus.id_is_branch && m_f.v;
                m_e.j  = bus.id_is_jal    && m_f.v;
                m_e.jr = bus.id_is_jalr   && m_f.v;
                m_f    = nf;
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;

        // Correct taken beq.
        set_in(32'h40, 32'h80, 5, 0, 0, 0, 0, 0, 0, 0, "beq_f");
        tick();
        set_in(32'h80, 32'h84, 6, 0, 1, 0, 0, 0, 0, 0, "beq_d");
        tick();
        set_in(32'h84, 32'h88, 7, 0, 0, 0, 0, 1, 32'h80, 0, "beq_ex");
        chk("beq.is_branch", 32'(bus.is_branch), 1);
        chk("beq.taken",     32'(bus.actual_taken), 1);
        chk("beq.correct",   32'(bus.prediction_correct), 1);
        chk("beq.idx",       32'(bus.pht_update_index), 5);
        chk("beq.redirect",  32'(bus.redirect), 0);
        tick();

        // Mispredicted not-taken.
        set_in(32'h40, 32'h80, 3, 0, 0, 0, 0, 0, 0, 0, "nt_f");
        tick();
        set_in(32'h80, 32'h84, 4, 0, 1, 0, 0, 0, 0, 0, "nt_d");
        tick();
        set_in(32'h84, 32'h88, 5, 0, 0, 0, 0, 0, 32'h80, 0, "nt_ex");
        chk("nt.redirect",   32'(bus.redirect), 1);
        chk("nt.redirect_pc", bus.redirect_pc, 32'h44);
        tick();
        set_in(32'h44, 32'h48, 0, 0, 0, 0, 0, 0, 0, 0, "nt_after");
        chk("nt.after_branch", 32'(bus.is_branch), 0);
        chk("nt.after_redir",  32'(bus.redirect), 0);
        tick();

        // jalr with odd base-plus-offset.
        set_in(32'h100, 32'h104, 9, 0, 0, 0, 0, 0, 0, 0, "jalr_f");
        tick();
        set_in(32'h104, 32'h108, 1, 0, 0, 0, 1, 0, 0, 0, "jalr_d");
        tick();
        set_in(32'h108, 32'h10C, 2, 0, 0, 0, 0, 0, 32'h500, 32'h201 & ~32'h1, "jalr_ex");
        chk("jalr.is_jalr", 32'(bus.is_jalr), 1);
        chk("jalr.taken",   32'(bus.actual_taken), 1);
        chk("jalr.rpc",     bus.redirect_pc, 32'h200);
        tick();

        // Stall coinciding with a mispredict, then stall alone.
        set_in(32'h40, 32'h80, 3, 0, 0, 0, 0, 0, 0, 0, "sr_f");
        tick();
        set_in(32'h80, 32'h84, 4, 0, 1, 0, 0, 0, 0, 0, "sr_d");
        tick();
        set_in(32'h84, 32'h88, 5, 1, 0, 0, 0, 0, 32'h80, 0, "sr_ex");
        chk("sr.redirect", 32'(bus.redirect), 1);
        tick();
        set_in(32'h200, 32'h204, 8, 0, 0, 0, 0, 0, 0, 0, "sr_squashed");
        chk("sr.ex_pc", bus.ID_EX_pc, 0);
        tick();
        set_in(32'h204, 32'h208, 9, 1, 0, 0, 0, 0, 0, 0, "st_hold");
        tick();
        set_in(32'h204, 32'h208, 9, 0, 0, 0, 0, 0, 0, 0, "st_bubble");
        chk("st.bubble_valid", bus.ID_EX_pc, 0);
        tick();
        set_in(32'h208, 32'h20C, 10, 0, 0, 0, 0, 0, 0, 0, "st_resume");
        chk("st.held_pc", bus.ID_EX_pc, 32'h200);
        tick();

        // PC wrap on not-taken branch.
        set_in(32'hFFFF_FFFC, 32'h10, 11, 0, 0, 0, 0, 0, 0, 0, "wrap_f");
        tick();
        set_in(32'h10, 32'h14, 12, 0, 1, 0, 0, 0, 0, 0, "wrap_d");
        tick();
        set_in(32'h14, 32'h18, 13, 0, 0, 0, 0, 0, 32'h10, 0, "wrap_ex");
        chk("wrap.rpc", bus.redirect_pc, 32'h0);
        chk("wrap.redirect", 32'(bus.redirect), 1);
        tick();

        // Asynchronous reset with both stages occupied.
        set_in(32'h300, 32'h304, 1, 0, 0, 0, 0, 0, 0, 0, "rst_f0");
        tick();
        set_in(32'h304, 32'h308, 2, 0, 1, 0, 0, 0, 0, 0, "rst_f1");
        tick();
        set_in(32'h308, 32'h30C, 3, 0, 0, 0, 0, 0, 32'h999, 0, "rst_full");
        chk("rst.pre_valid", bus.ID_EX_pc, 32'h300);
        reset = 1'b1;
        model_reset();
        #1;
        check_all("rst_mid");
        chk("rst.redirect", 32'(bus.redirect), 0);
        tick();
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic; small address pool makes correct predictions frequent.
        for (int i = 0; i < 400; i++) begin
            int unsigned k;
            logic [31:0] pc, npc, bt, jt;
            pc  = 32'($urandom_range(0, 15)) * 4;
            npc = 32'($urandom_range(0, 19)) * 4;
            bt  = 32'($urandom_range(0, 19)) * 4;
            jt  = 32'($urandom_range(0, 19)) * 4;
            k   = $urandom_range(0, 3);
            set_in(pc, npc, 5'($urandom), ($urandom_range(0, 4) == 0),
                   (k == 1), (k == 2), (k == 3), 1'($urandom),
                   bt, jt, "rand");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
